// File: rtl/mips_pkg.sv
// Shared encodings, ALU operations, control bundle and address map for mips_core.
package mips_pkg;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;

  typedef enum logic [5:0] {
    FN_SLL = 6'h00,
    FN_ADD = 6'h20,
    FN_SUB = 6'h22,
    FN_AND = 6'h24,
    FN_OR  = 6'h25,
    FN_SLT = 6'h2A
  } funct_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4,
    ALU_SLL = 3'd5
  } alu_op_e;

  typedef struct packed {
    logic    reg_we;
    logic    mem_we;
    logic    mem_to_reg;
    logic    alu_src_imm;
    logic    dst_rd;
    logic    branch;
    logic    branch_ne;
    logic    jump;
    alu_op_e alu_op;
  } ctrl_t;

  localparam logic [31:0] TEXT_BASE = 32'h0040_0000;
  localparam logic [31:0] DATA_BASE = 32'h1001_0000;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/mips_data_mem.sv
// Word-addressed data memory: combinational read, write committed on the clock edge.
module mips_data_mem #(
  parameter int DEPTH = 256
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [31:0]              wdata_i,
  output logic [31:0]              rdata_o
);

  logic [31:0] data_mem_ff [0:DEPTH-1];

  // Store path; held off while reset is asserted.
  always_ff @(posedge clk_i) begin
    if (rst_ni && we_i) begin
      data_mem_ff[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = data_mem_ff[addr_i];

endmodule

// File: rtl/mips_header.svh
// Build-wide sizing macros for the mips_core datapath.
`ifndef MIPS_HEADER_SVH
`define MIPS_HEADER_SVH

`define DATA_MEM_DEPTH 256

`endif

// File: rtl/mips_instr_mem.sv
// 512-word instruction store with a combinational fetch port and a spare load port.
module mips_instr_mem (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [8:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [8:0]  raddr_i,
  output logic [31:0] rdata_o
);

  logic [31:0] regData [0:511];

  // Load port, normally tied off; contents are placed by hierarchy.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      regData[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = regData[raddr_i];

endmodule

// File: rtl/mips_reg_bank.sv
// 32x32 register bank: two combinational read ports, one write port; $0 is hardwired to zero.
module mips_reg_bank (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [4:0]  rs_addr_i,
  input  logic [4:0]  rt_addr_i,
  output logic [31:0] rs_data_o,
  output logic [31:0] rt_data_o,
  input  logic        we_i,
  input  logic [4:0]  wr_addr_i,
  input  logic [31:0] wr_data_i
);

  logic [31:0] reg_file_ff [0:31];

  // Write port; no clear on reset so preloaded contents survive it.
  always_ff @(posedge clk_i) begin
    if (rst_ni && we_i && (wr_addr_i != 5'd0)) begin
      reg_file_ff[wr_addr_i] <= wr_data_i;
    end
  end

  assign rs_data_o = (rs_addr_i == 5'd0) ? 32'd0 : reg_file_ff[rs_addr_i];
  assign rt_data_o = (rt_addr_i == 5'd0) ? 32'd0 : reg_file_ff[rt_addr_i];

endmodule

// File: rtl/mips_core.sv
// Single-cycle MIPS-I subset core: fetch, decode, execute, memory and writeback in one clock.
`include "mips_header.svh"

module mips_core
  import mips_pkg::*;
#(
  parameter int DATA_MEM_DEPTH = `DATA_MEM_DEPTH
) (
  input logic clk,
  input logic rst
);

  localparam int DAW = $clog2(DATA_MEM_DEPTH);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4_s, br_target_s, jmp_target_s;
  logic [31:0] instr_s, imm_sext_s;
  logic [31:0] rs_data_s, rt_data_s, alu_b_s, alu_res_s;
  logic [31:0] mem_rdata_s, wb_data_s, data_off_s;
  logic [4:0]  rs_s, rt_s, rd_s, shamt_s, wr_addr_s;
  logic        eq_s, take_br_s;
  opcode_e     op_s;
  funct_e      funct_s;
  ctrl_t       ctrl_s;
  logic        unused_s;

  assign op_s       = opcode_e'(instr_s[31:26]);
  assign funct_s    = funct_e'(instr_s[5:0]);
  assign rs_s       = instr_s[25:21];
  assign rt_s       = instr_s[20:16];
  assign rd_s       = instr_s[15:11];
  assign shamt_s    = instr_s[10:6];
  assign imm_sext_s = sext16(instr_s[15:0]);

  mips_instr_mem InstructionMemory (
    .clk_i   (clk),
    .we_i    (1'b0),
    .waddr_i (9'd0),
    .wdata_i (32'd0),
    .raddr_i (pc_q[10:2]),
    .rdata_o (instr_s)
  );

  mips_reg_bank RegBank (
    .clk_i     (clk),
    .rst_ni    (rst),
    .rs_addr_i (rs_s),
    .rt_addr_i (rt_s),
    .rs_data_o (rs_data_s),
    .rt_data_o (rt_data_s),
    .we_i      (ctrl_s.reg_we),
    .wr_addr_i (wr_addr_s),
    .wr_data_i (wb_data_s)
  );

  mips_data_mem #(
    .DEPTH (DATA_MEM_DEPTH)
  ) DataMemory (
    .clk_i   (clk),
    .rst_ni  (rst),
    .we_i    (ctrl_s.mem_we),
    .addr_i  (data_off_s[DAW+1:2]),
    .wdata_i (rt_data_s),
    .rdata_o (mem_rdata_s)
  );

  // Instruction decode; anything unrecognised falls through as a nop.
  always_comb begin
    ctrl_s             = '0;
    ctrl_s.alu_op      = ALU_ADD;
    case (op_s)
      OP_RTYPE: begin
        ctrl_s.dst_rd = 1'b1;
        case (funct_s)
          FN_ADD: begin ctrl_s.reg_we = 1'b1; ctrl_s.alu_op = ALU_ADD; end
          FN_SUB: begin ctrl_s.reg_we = 1'b1; ctrl_s.alu_op = ALU_SUB; end
          FN_AND: begin ctrl_s.reg_we = 1'b1; ctrl_s.alu_op = ALU_AND; end
          FN_OR:  begin ctrl_s.reg_we = 1'b1; ctrl_s.alu_op = ALU_OR;  end
          FN_SLT: begin ctrl_s.reg_we = 1'b1; ctrl_s.alu_op = ALU_SLT; end
          FN_SLL: begin ctrl_s.reg_we = 1'b1; ctrl_s.alu_op = ALU_SLL; end
          default: ctrl_s.reg_we = 1'b0;
        endcase
      end
      OP_ADDI: begin
        ctrl_s.reg_we      = 1'b1;
        ctrl_s.alu_src_imm = 1'b1;
      end
      OP_LW: begin
        ctrl_s.reg_we      = 1'b1;
        ctrl_s.mem_to_reg  = 1'b1;
        ctrl_s.alu_src_imm = 1'b1;
      end
      OP_SW: begin
        ctrl_s.mem_we      = 1'b1;
        ctrl_s.alu_src_imm = 1'b1;
      end
      OP_BEQ: ctrl_s.branch = 1'b1;
      OP_BNE: begin
        ctrl_s.branch    = 1'b1;
        ctrl_s.branch_ne = 1'b1;
      end
      OP_J:    ctrl_s.jump = 1'b1;
      default: ctrl_s.reg_we = 1'b0;
    endcase
  end

  assign alu_b_s = ctrl_s.alu_src_imm ? imm_sext_s : rt_data_s;

  // ALU; sll shifts the rt operand by shamt.
  always_comb begin
    alu_res_s = 32'd0;
    case (ctrl_s.alu_op)
      ALU_ADD: alu_res_s = rs_data_s + alu_b_s;
      ALU_SUB: alu_res_s = rs_data_s - alu_b_s;
      ALU_AND: alu_res_s = rs_data_s & alu_b_s;
      ALU_OR:  alu_res_s = rs_data_s | alu_b_s;
      ALU_SLT: alu_res_s = {31'd0, ($signed(rs_data_s) < $signed(alu_b_s))};
      ALU_SLL: alu_res_s = alu_b_s << shamt_s;
      default: alu_res_s = 32'd0;
    endcase
  end

  // Offset from the data segment base; only the word-index bits reach memory.
  assign data_off_s = alu_res_s - DATA_BASE;
  assign unused_s   = ^{data_off_s[31:DAW+2], data_off_s[1:0]};

  assign wb_data_s = ctrl_s.mem_to_reg ? mem_rdata_s : alu_res_s;
  assign wr_addr_s = ctrl_s.dst_rd ? rd_s : rt_s;

  assign pc_plus4_s   = pc_q + 32'd4;
  assign br_target_s  = pc_plus4_s + {imm_sext_s[29:0], 2'b00};
  assign jmp_target_s = {pc_plus4_s[31:28], instr_s[25:0], 2'b00};
  assign eq_s         = (rs_data_s == rt_data_s);
  assign take_br_s    = ctrl_s.branch & (eq_s ^ ctrl_s.branch_ne);

  // Next-PC selection; no delay slot, so redirects take effect immediately.
  always_comb begin
    if (ctrl_s.jump) begin
      pc_d = jmp_target_s;
    end else if (take_br_s) begin
      pc_d = br_target_s;
    end else begin
      pc_d = pc_plus4_s;
    end
  end

  // Program counter register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q <= TEXT_BASE;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: tb/tb_mips_core.sv
// Directed self-checking bench for mips_core using hierarchical preload/inspection.
module tb_mips_core;

  localparam logic [31:0] TB_TEXT_BASE = 32'h0040_0000;
  localparam logic [31:0] TB_DATA_BASE = 32'h1001_0000;

  logic        clk;
  logic        rst;
  int          checks;
  int          errors;
  logic [31:0] exp_pc;

  mips_core dut (
    .clk (clk),
    .rst (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                        input int sh, input logic [5:0] fn);
    logic [4:0] a, b, c, d;
    a = rs[4:0]; b = rt[4:0]; c = rd[4:0]; d = sh[4:0];
    return {6'h00, a, b, c, d, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                        input logic [15:0] imm);
    logic [4:0] a, b;
    a = rs[4:0]; b = rt[4:0];
    return {op, a, b, imm};
  endfunction

  function automatic logic [31:0] next_main_pc(input logic [31:0] pc);
    if (pc == 32'h0040_0010 || pc == 32'h0040_0040) return 32'h0040_002C;
    return pc + 32'd4;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_all();
    for (int i = 0; i < 512; i++) dut.InstructionMemory.regData[i] = 32'd0;
    for (int i = 0; i < 32; i++)  dut.RegBank.reg_file_ff[i] = 32'd0;
    for (int i = 0; i < 256; i++) dut.DataMemory.data_mem_ff[i] = 32'd0;
  endtask

  task automatic load_main_prog();
    dut.InstructionMemory.regData[1]  = enc_i(6'h08, 0, 1, 16'd1);
    dut.InstructionMemory.regData[2]  = enc_i(6'h08, 0, 15, 16'd15);
    dut.InstructionMemory.regData[3]  = enc_r(1, 15, 16, 0, 6'h20);
    dut.InstructionMemory.regData[4]  = {6'h02, 26'h010_000B};
    dut.InstructionMemory.regData[5]  = enc_i(6'h08, 0, 10, 16'd10);
    dut.InstructionMemory.regData[6]  = enc_i(6'h08, 0, 11, 16'd11);
    dut.InstructionMemory.regData[11] = enc_r(1, 1, 2, 0, 6'h20);
    dut.InstructionMemory.regData[16] = enc_i(6'h04, 0, 0, 16'hFFFA);
    dut.InstructionMemory.regData[17] = enc_r(0, 16, 12, 0, 6'h25);
  endtask

  task automatic test_reset();
    clear_all();
    load_main_prog();
    rst = 1'b0;
    tick();
    checks++;
    if (dut.pc_q !== TB_TEXT_BASE) begin
      errors++; $display("FAIL reset_pc: got %h expected %h", dut.pc_q, TB_TEXT_BASE);
    end
    tick();
    checks++;
    if (dut.pc_q !== TB_TEXT_BASE) begin
      errors++; $display("FAIL reset_pc_hold: got %h expected %h", dut.pc_q, TB_TEXT_BASE);
    end
    rst = 1'b1;
  endtask

  task automatic test_jump_branch();
    int          regs [7];
    logic [31:0] vals [7];
    regs = '{1, 15, 16, 2, 10, 11, 12};
    vals = '{32'd1, 32'd15, 32'd16, 32'd2, 32'd0, 32'd0, 32'd0};
    exp_pc = TB_TEXT_BASE;
    for (int c = 0; c < 40; c++) begin
      tick();
      exp_pc = next_main_pc(exp_pc);
      checks++;
      if (dut.pc_q !== exp_pc) begin
        errors++; $display("FAIL loop_pc cycle %0d: got %h expected %h", c, dut.pc_q, exp_pc);
      end
    end
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (dut.RegBank.reg_file_ff[regs[k]] !== vals[k]) begin
        errors++;
        $display("FAIL prog_reg $%0d: got %h expected %h", regs[k],
                 dut.RegBank.reg_file_ff[regs[k]], vals[k]);
      end
    end
  endtask

  task automatic test_reset_midloop();
    for (int k = 0; k < 8 && exp_pc != 32'h0040_002C; k++) begin
      tick();
      exp_pc = next_main_pc(exp_pc);
    end
    checks++;
    if (dut.pc_q !== 32'h0040_002C) begin
      errors++; $display("FAIL midloop_align: got %h expected %h", dut.pc_q, 32'h0040_002C);
    end
    dut.RegBank.reg_file_ff[2] = 32'h0000_1234;
    rst = 1'b0;
    tick();
    checks++;
    if (dut.pc_q !== TB_TEXT_BASE) begin
      errors++; $display("FAIL midloop_pc: got %h expected %h", dut.pc_q, TB_TEXT_BASE);
    end
    checks++;
    if (dut.RegBank.reg_file_ff[2] !== 32'h0000_1234) begin
      errors++; $display("FAIL midloop_nowrite: got %h expected %h",
                         dut.RegBank.reg_file_ff[2], 32'h0000_1234);
    end
    checks++;
    if (dut.RegBank.reg_file_ff[16] !== 32'd16 || dut.RegBank.reg_file_ff[1] !== 32'd1) begin
      errors++; $display("FAIL midloop_keep: got %h/%h expected %h/%h",
                         dut.RegBank.reg_file_ff[16], dut.RegBank.reg_file_ff[1], 32'd16, 32'd1);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (dut.pc_q !== 32'h0040_0004) begin
      errors++; $display("FAIL midloop_restart: got %h expected %h", dut.pc_q, 32'h0040_0004);
    end
  endtask

  task automatic test_mem_access();
    clear_all();
    dut.InstructionMemory.regData[0] = enc_i(6'h2B, 31, 16, 16'd4);
    dut.InstructionMemory.regData[1] = enc_i(6'h23, 31, 3, 16'd4);
    rst = 1'b0;
    dut.RegBank.reg_file_ff[31] = TB_DATA_BASE;
    dut.RegBank.reg_file_ff[16] = 32'd16;
    tick();
    checks++;
    if (dut.RegBank.reg_file_ff[31] !== TB_DATA_BASE) begin
      errors++; $display("FAIL mem_preload_kept: got %h expected %h",
                         dut.RegBank.reg_file_ff[31], TB_DATA_BASE);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (dut.DataMemory.data_mem_ff[1] !== 32'd16) begin
      errors++; $display("FAIL sw_word1: got %h expected %h", dut.DataMemory.data_mem_ff[1], 32'd16);
    end
    checks++;
    if (dut.DataMemory.data_mem_ff[0] !== 32'd0) begin
      errors++; $display("FAIL sw_word0: got %h expected %h", dut.DataMemory.data_mem_ff[0], 32'd0);
    end
    tick();
    checks++;
    if (dut.RegBank.reg_file_ff[3] !== 32'd16) begin
      errors++; $display("FAIL lw_r3: got %h expected %h", dut.RegBank.reg_file_ff[3], 32'd16);
    end
  endtask

  task automatic test_zero_reg();
    clear_all();
    dut.InstructionMemory.regData[0] = enc_i(6'h08, 0, 0, 16'd5);
    dut.InstructionMemory.regData[1] = enc_r(0, 0, 4, 0, 6'h20);
    rst = 1'b0;
    dut.RegBank.reg_file_ff[4] = 32'h0000_DEAD;
    tick();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (dut.RegBank.reg_file_ff[4] !== 32'd0) begin
      errors++; $display("FAIL zero_reg: got %h expected %h", dut.RegBank.reg_file_ff[4], 32'd0);
    end
  endtask

  task automatic test_arith();
    int          regs [12];
    logic [31:0] vals [12];
    clear_all();
    dut.InstructionMemory.regData[0]  = enc_i(6'h08, 0, 5, 16'hFFFF);
    dut.InstructionMemory.regData[1]  = enc_r(5, 0, 6, 0, 6'h2A);
    dut.InstructionMemory.regData[2]  = enc_r(9, 1, 13, 0, 6'h20);
    dut.InstructionMemory.regData[3]  = enc_r(0, 1, 7, 4, 6'h00);
    dut.InstructionMemory.regData[4]  = enc_r(1, 9, 14, 0, 6'h22);
    dut.InstructionMemory.regData[5]  = enc_r(5, 15, 17, 0, 6'h24);
    dut.InstructionMemory.regData[6]  = enc_r(9, 13, 18, 0, 6'h25);
    dut.InstructionMemory.regData[7]  = enc_r(0, 5, 19, 0, 6'h2A);
    dut.InstructionMemory.regData[8]  = enc_i(6'h05, 1, 0, 16'd1);
    dut.InstructionMemory.regData[9]  = enc_i(6'h08, 0, 20, 16'd7);
    dut.InstructionMemory.regData[10] = enc_i(6'h3F, 0, 21, 16'h1234);
    dut.InstructionMemory.regData[11] = enc_r(1, 1, 21, 0, 6'h21);
    dut.InstructionMemory.regData[12] = enc_i(6'h04, 1, 0, 16'd1);
    dut.InstructionMemory.regData[13] = enc_i(6'h08, 0, 22, 16'd3);
    rst = 1'b0;
    dut.RegBank.reg_file_ff[1]  = 32'd1;
    dut.RegBank.reg_file_ff[9]  = 32'h7FFF_FFFF;
    dut.RegBank.reg_file_ff[15] = 32'h0000_F0F0;
    dut.RegBank.reg_file_ff[19] = 32'h0000_0077;
    dut.RegBank.reg_file_ff[21] = 32'h0000_0055;
    tick();
    rst = 1'b1;
    repeat (16) tick();
    regs = '{5, 6, 13, 7, 14, 17, 18, 19, 20, 21, 22, 1};
    vals = '{32'hFFFF_FFFF, 32'd1, 32'h8000_0000, 32'd16, 32'h8000_0002, 32'h0000_F0F0,
             32'hFFFF_FFFF, 32'd0, 32'd0, 32'h0000_0055, 32'd3, 32'd1};
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (dut.RegBank.reg_file_ff[regs[k]] !== vals[k]) begin
        errors++;
        $display("FAIL arith_reg $%0d: got %h expected %h", regs[k],
                 dut.RegBank.reg_file_ff[regs[k]], vals[k]);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    exp_pc = TB_TEXT_BASE;
    test_reset();
    test_jump_branch();
    test_reset_midloop();
    test_mem_access();
    test_zero_reg();
    test_arith();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
